// File: rtl/mic_pkg.sv
// Shared definitions for the microphone front end: channel count, sample
// width, the adder-tree sum width and common sample/frame types.
package mic_pkg;

  localparam int MIC_CHANNELS = 16;
  localparam int MIC_SAMPLE_W = 19;
  localparam int MIC_SUM_W    = 23;

  typedef logic signed [MIC_SAMPLE_W-1:0] sample_t;
  typedef sample_t frame_t [MIC_CHANNELS];

  // Saturating increment for 8-bit event counters (sticks at 255).
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return 8'hFF;
    end else begin
      return v + 8'h01;
    end
  endfunction

endpackage

// File: rtl/mic_frame_assembler.sv
// Gathers a channel-serial sample stream into a double-buffered parallel
// frame for the beamformer adder tree. The fill buffer keeps collecting the
// next frame while the hold buffer is presented to the consumer; only the
// final beat of a frame can be back-pressured.
module mic_frame_assembler
  import mic_pkg::*;
#(
  parameter int CHANNELS = MIC_CHANNELS,
  parameter int SAMPLE_W = MIC_SAMPLE_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SAMPLE_W-1:0]          s_data,
  input  logic                         s_valid,
  input  logic                         s_first,
  output logic                         s_ready,
  output logic [CHANNELS*SAMPLE_W-1:0] frame_data,
  output logic                         frame_valid,
  input  logic                         frame_ready,
  output logic                         sync_err,
  output logic [7:0]                   drop_cnt
);

  localparam int CNT_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHANNELS - 1);

  logic [SAMPLE_W-1:0] fill_q [CHANNELS];
  logic [SAMPLE_W-1:0] fill_d [CHANNELS];
  logic [SAMPLE_W-1:0] hold_q [CHANNELS];
  logic [SAMPLE_W-1:0] hold_d [CHANNELS];
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                frame_valid_q;
  logic                frame_valid_d;
  logic                sync_err_q;
  logic                sync_err_d;
  logic [7:0]          drop_cnt_q;
  logic [7:0]          drop_cnt_d;

  logic                beat_acc_s;
  logic                consume_s;
  logic                complete_s;

  // The last beat may only land when the hold buffer is free or being drained.
  assign s_ready    = !rst && ((cnt_q != CNT_LAST) || !frame_valid_q || frame_ready);
  assign beat_acc_s = s_valid && s_ready;
  assign consume_s  = frame_valid_q && frame_ready;

  // Next-state: fill write, index advance, resync accounting, frame hand-off.
  always_comb begin
    fill_d        = fill_q;
    hold_d        = hold_q;
    cnt_d         = cnt_q;
    frame_valid_d = frame_valid_q;
    sync_err_d    = 1'b0;
    drop_cnt_d    = drop_cnt_q;
    complete_s    = 1'b0;

    if (beat_acc_s) begin
      if (s_first) begin
        fill_d[0] = s_data;
        if (cnt_q != CNT_ZERO) begin
          // A new channel 0 arrived before the previous frame finished.
          sync_err_d = 1'b1;
          drop_cnt_d = sat_inc8(drop_cnt_q);
        end else begin
          drop_cnt_d = drop_cnt_q;
        end
        if (CHANNELS == 1) begin
          cnt_d      = CNT_ZERO;
          complete_s = 1'b1;
        end else begin
          cnt_d = CNT_ONE;
        end
      end else begin
        fill_d[cnt_q] = s_data;
        if (cnt_q == CNT_LAST) begin
          cnt_d      = CNT_ZERO;
          complete_s = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    end else begin
      cnt_d = cnt_q;
    end

    if (complete_s) begin
      hold_d        = fill_d;
      frame_valid_d = 1'b1;
    end else if (consume_s) begin
      frame_valid_d = 1'b0;
    end else begin
      frame_valid_d = frame_valid_q;
    end
  end

  // State registers; reset discards both the partial fill and any held frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < CHANNELS; k++) begin
        fill_q[k] <= {SAMPLE_W{1'b0}};
        hold_q[k] <= {SAMPLE_W{1'b0}};
      end
      cnt_q         <= CNT_ZERO;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      drop_cnt_q    <= 8'h00;
    end else begin
      fill_q        <= fill_d;
      hold_q        <= hold_d;
      cnt_q         <= cnt_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // Channel k occupies lane k of the flat adder-tree bus, bit-exact.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    assign frame_data[SAMPLE_W*k +: SAMPLE_W] = hold_q[k];
  end

  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_mic_frame_assembler.sv
// Self-checking bench for mic_frame_assembler: directed scenarios followed by
// randomized traffic, all compared against a queue-based frame model.
module tb_mic_frame_assembler;

  localparam int CH = 16;
  localparam int SW = 19;
  localparam int FW = CH * SW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [SW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_first = 1'b0;
  logic          s_ready;
  logic [FW-1:0] frame_data;
  logic          frame_valid;
  logic          frame_ready = 1'b0;
  logic          sync_err;
  logic [7:0]    drop_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model state: samples of the frame in progress, the frame held
  // for the consumer, and the expected error outputs.
  logic [SW-1:0] partial[$];
  logic [SW-1:0] held[CH];
  bit            held_valid;
  int            drops;
  bit            exp_err;
  bit            g_fready;

  mic_frame_assembler dut (
    .clk         (clk),
    .rst         (rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_first     (s_first),
    .s_ready     (s_ready),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .sync_err    (sync_err),
    .drop_cnt    (drop_cnt)
  );

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  // Hard stop in case the stimulus itself wedges.
  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  function automatic logic [FW-1:0] pack_held();
    logic [FW-1:0] r;
    r = '0;
    for (int k = 0; k < CH; k++) r[SW*k +: SW] = held[k];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    partial.delete();
    for (int k = 0; k < CH; k++) held[k] = '0;
    held_valid = 1'b0;
    drops = 0;
    exp_err = 1'b0;
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ".frame_valid"}, FW'(frame_valid), FW'(held_valid));
    chk({ctx, ".sync_err"},    FW'(sync_err),    FW'(exp_err));
    chk({ctx, ".drop_cnt"},    FW'(drop_cnt),    FW'(drops));
    chk({ctx, ".frame_data"},  frame_data,       pack_held());
  endtask

  // One clock cycle: drive, check readiness, advance model, check outputs.
  task automatic cycle(input logic v, input logic f, input logic [SW-1:0] d, output bit acc);
    bit exp_ready;
    bit consume;
    bit done;
    s_valid = v;
    s_first = f;
    s_data = d;
    frame_ready = g_fready;
    #2;
    exp_ready = !(partial.size() == CH - 1 && held_valid && !g_fready);
    chk("s_ready", FW'(s_ready), FW'(exp_ready));
    consume = held_valid && g_fready;
    acc = v && exp_ready;
    exp_err = 1'b0;
    done = 1'b0;
    if (acc) begin
      if (f) begin
        if (partial.size() != 0) begin
          exp_err = 1'b1;
          drops = (drops >= 255) ? 255 : drops + 1;
        end
        partial.delete();
      end
      partial.push_back(d);
      if (partial.size() == CH) begin
        for (int k = 0; k < CH; k++) held[k] = partial[k];
        partial.delete();
        done = 1'b1;
      end
    end
    if (done) held_valid = 1'b1;
    else if (consume) held_valid = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("cyc");
  endtask

  // Offer one beat until accepted; release back-pressure after a short stall.
  task automatic send_beat(input logic f, input logic [SW-1:0] d);
    bit acc;
    int tries;
    tries = 0;
    acc = 1'b0;
    while (!acc && tries < 40) begin
      cycle(1'b1, f, d, acc);
      tries++;
      if (!acc && tries >= 4) g_fready = 1'b1;
    end
    checks++;
    assert (acc) else begin
      failures++;
      $error("FAIL beat_accept observed=%0d expected=1", acc);
    end
  endtask

  task automatic send_frame(input logic [SW-1:0] base, input int step);
    for (int k = 0; k < CH; k++) send_beat(k == 0, base + SW'(k * step));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    s_valid = 1'b0;
    s_first = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < n; i++) begin
      chk("rst.s_ready", FW'(s_ready), FW'(0));
      check_outputs("rst");
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  initial begin
    bit acc;
    logic [SW-1:0] neg_vals[CH];

    // Reset state and release.
    g_fready = 1'b1;
    @(posedge clk);
    #1;
    do_reset(3);

    // Counting frame 1..16 with consumer always ready.
    for (int k = 0; k < CH; k++) send_beat(k == 0, SW'(k + 1));
    chk("count.lane0", FW'(frame_data[SW-1:0]), FW'(1));
    chk("count.lane15", FW'(frame_data[SW*15 +: SW]), FW'(16));
    cycle(1'b0, 1'b0, '0, acc);

    // Negative extremes placed in distinct lanes.
    for (int k = 0; k < CH; k++) begin
      neg_vals[k] = (k % 2 == 0) ? 19'h7FFFF : 19'h40000;
      if (k == 5) neg_vals[k] = 19'h3FFFF;
    end
    for (int k = 0; k < CH; k++) send_beat(k == 0, neg_vals[k]);
    chk("neg.lane1", FW'(frame_data[SW*1 +: SW]), FW'(19'h40000));
    chk("neg.lane14", FW'(frame_data[SW*14 +: SW]), FW'(19'h7FFFF));

    // Two frames with consumer stalled: last beat of the second must wait.
    g_fready = 1'b0;
    send_frame(19'h01000, 3);
    send_frame(19'h02000, 7);
    cycle(1'b0, 1'b0, '0, acc);

    // Resync in mid-frame at index 7, then a clean frame.
    g_fready = 1'b1;
    for (int k = 0; k < 7; k++) send_beat(k == 0, SW'(19'h10000 + k));
    send_frame(19'h05000, 1);
    chk("resync.drops", FW'(drop_cnt), FW'(1));

    // Repeated resyncs drive the drop counter into saturation.
    for (int i = 0; i < 300; i++) begin
      send_beat(1'b1, SW'(i));
      send_beat(1'b0, SW'(i + 1));
    end
    send_beat(1'b1, 19'h00123);
    chk("sat.drops", FW'(drop_cnt), FW'(255));

    // Reset with a held frame and a partial fill at index 9.
    g_fready = 1'b0;
    send_frame(19'h06000, 2);
    for (int k = 0; k < 9; k++) send_beat(k == 0, SW'(19'h07000 + k));
    chk("pre_rst.valid", FW'(frame_valid), FW'(1));
    do_reset(2);
    g_fready = 1'b1;
    send_frame(19'h08000, 5);
    cycle(1'b0, 1'b0, '0, acc);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      g_fready = ($urandom_range(0, 3) != 0);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
            SW'($urandom), acc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
